// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding, operand/op select bit indices and default width for the ALU.
package alu_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [1:0] {
        OFF     = 2'b00,
        READY   = 2'b01,
        RUNNING = 2'b10,
        RUN_ERR = 2'b11
    } state_t;
    localparam int OP_AND = 0;
    localparam int OP_OR  = 1;
    localparam int OP_XOR = 2;
    localparam int OP_NOT = 3;
    localparam int OP_ADD = 4;
    localparam int OP_SUB = 5;
    localparam int OP_MUL = 6;
    localparam int SEL_PERSIST = 0;
    localparam int SEL_LOAD    = 1;
    localparam int SEL_CLEAR   = 2;
endpackage

// File: rtl/alu_if.sv
// alu_if: ALU operand/op request bundle plus result, operand and state visibility.
interface alu_if #(parameter int WIDTH = 8);
    logic             on;
    logic [2:0]       in_sel;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic [6:0]       out_sel;
    logic [WIDTH-1:0] final1;
    logic [WIDTH-1:0] final2;
    logic [WIDTH-1:0] out;
    logic [1:0]       currState;
    logic [1:0]       nextState;
    modport master (
        output on, in_sel, num1, num2, out_sel,
        input  final1, final2, out, currState, nextState
    );
    modport slave (
        input  on, in_sel, num1, num2, out_sel,
        output final1, final2, out, currState, nextState
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational one-hot-priority ALU producing a WIDTH-bit result and an overflow/underflow flag.
// ALU_SATURATE_EN: on err, MUL/ADD clamp to all-ones and SUB clamps to zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [6:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_err
);
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_sum;
    assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        if (i_op[OP_MUL]) begin
            o_result = w_prod[WIDTH-1:0];
            o_err    = |w_prod[2*WIDTH-1:WIDTH];
        end else if (i_op[OP_SUB]) begin
            o_result = i_a - i_b;
            o_err    = i_a < i_b;
        end else if (i_op[OP_ADD]) begin
            o_result = w_sum[WIDTH-1:0];
            o_err    = w_sum[WIDTH];
        end else if (i_op[OP_NOT]) begin
            o_result = ~i_a;
        end else if (i_op[OP_XOR]) begin
            o_result = i_a ^ i_b;
        end else if (i_op[OP_OR]) begin
            o_result = i_a | i_b;
        end else if (i_op[OP_AND]) begin
            o_result = i_a & i_b;
        end
`ifdef ALU_SATURATE_EN
        // err only arises from MUL, SUB or ADD; SUB outranks ADD in the priority chain
        if (o_err)
            o_result = (i_op[OP_MUL] || !i_op[OP_SUB]) ? '1 : '0;
`endif
    end
endmodule

// File: rtl/alu_main.sv
// alu_main: registered accumulator ALU with operand muxing and an Off/Ready/Running/RunErr power state machine.
// Optional ALU_SATURATE_EN (in alu_core) clamps overflowing results instead of truncating.
module alu_main
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);
    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;
    logic             w_err;
    logic             w_clear;
    assign w_clear = bus.in_sel[SEL_CLEAR];
    assign w_a = w_clear               ? '0       :
                 bus.in_sel[SEL_LOAD]    ? bus.num1 :
                 bus.in_sel[SEL_PERSIST] ? r_out    : bus.num1;
    assign w_b = w_clear ? '0 : bus.num2;
    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_a      (w_a),
        .i_b      (w_b),
        .i_op     (bus.out_sel),
        .o_result (w_result),
        .o_err    (w_err)
    );
    // clear overrides err in Running/RunErr, so a cleared cycle never reports an error
    always_comb begin
        w_next = !bus.on                            ? OFF     :
                 (r_state == OFF)                   ? READY   :
                 (r_state == READY)                 ? RUNNING :
                 (w_clear || r_state == RUN_ERR)    ? READY   :
                 w_err                              ? RUN_ERR : RUNNING;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= OFF;
            r_out   <= '0;
        end else begin
            r_state <= w_next;
            if (bus.on)
                r_out <= w_clear ? '0 : w_result;
        end
    end
    assign bus.final1    = w_a;
    assign bus.final2    = w_b;
    assign bus.out       = r_out;
    assign bus.currState = r_state;
    assign bus.nextState = w_next;
endmodule

// File: tb/tb_alu_main.sv
// tb_alu_main: scoreboard bench for alu_main; expected out/state queued at drive time, compared after each edge.
module tb_alu_main;
    import alu_pkg::*;
    typedef struct packed {
        logic [7:0] out;
        logic [1:0] state;
    } obs_t;
    localparam logic [6:0] K_MUL = 7'b1000000;
    localparam logic [6:0] K_SUB = 7'b0100000;
    localparam logic [6:0] K_ADD = 7'b0010000;
    localparam logic [6:0] K_NOT = 7'b0001000;
    localparam logic [6:0] K_XOR = 7'b0000100;
    localparam logic [6:0] K_OR  = 7'b0000010;
    localparam logic [6:0] K_AND = 7'b0000001;
`ifdef ALU_SATURATE_EN
    localparam logic [7:0] MUL_OVF = 8'hFF;
    localparam logic [7:0] SUB_UNF = 8'h00;
    localparam logic [7:0] ADD_OVF = 8'hFF;
`else
    localparam logic [7:0] MUL_OVF = 8'hD6;
    localparam logic [7:0] SUB_UNF = 8'hFE;
    localparam logic [7:0] ADD_OVF = 8'h2C;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    obs_t exp_q[$];
    obs_t got_q[$];
    alu_if #(.WIDTH(8)) bus();
    alu_main #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    task automatic drive(input logic [2:0] s, input logic [7:0] n1, input logic [7:0] n2, input logic [6:0] op);
        bus.in_sel  = s;
        bus.num1    = n1;
        bus.num2    = n2;
        bus.out_sel = op;
        #1;
    endtask
    task automatic tick(input logic [7:0] eo, input state_t es);
        exp_q.push_back({eo, 2'(es)});
        @(posedge clk);
        @(negedge clk);
        got_q.push_back({bus.out, bus.currState});
    endtask
    task automatic test_reset();
        bus.on = 1'b0;
        drive(3'b000, 8'd0, 8'd0, 7'd0);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out !== 8'd0) begin errors++; $display("FAIL reset_out got=%h exp=00", bus.out); end
        checks++;
        if (bus.currState !== OFF) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.currState); end
        rst = 1'b1;
    endtask
    task automatic test_mul();
        obs_t e, g;
        bus.on = 1'b1;
        drive(3'b010, 8'd3, 8'd2, K_MUL);
        checks++;
        if (bus.nextState !== READY) begin errors++; $display("FAIL mul_next got=%0d exp=1", bus.nextState); end
        tick(8'd6, READY);
        tick(8'd6, RUNNING);
        drive(3'b010, 8'd87, 8'd26, K_MUL);
        checks++;
        if (bus.nextState !== RUN_ERR) begin errors++; $display("FAIL mul_ovf_next got=%0d exp=3", bus.nextState); end
        tick(MUL_OVF, RUN_ERR);
        drive(3'b010, 8'd1, 8'd1, K_MUL);
        tick(8'd1, READY);
        tick(8'd1, RUNNING);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL mul out/state got=%h/%0d exp=%h/%0d", g.out, g.state, e.out, e.state); end
        end
    endtask
    task automatic test_sub_clear();
        obs_t e, g;
        drive(3'b010, 8'd2, 8'd4, K_SUB);
        checks++;
        if (bus.nextState !== RUN_ERR) begin errors++; $display("FAIL sub_next got=%0d exp=3", bus.nextState); end
        tick(SUB_UNF, RUN_ERR);
        drive(3'b100, 8'd2, 8'd4, K_SUB);
        checks++;
        if (bus.final1 !== 8'd0 || bus.final2 !== 8'd0) begin
            errors++; $display("FAIL clear_operands got=%h,%h exp=00,00", bus.final1, bus.final2);
        end
        tick(8'd0, READY);
        drive(3'b010, 8'd5, 8'd5, K_AND);
        tick(8'd5, RUNNING);
        drive(3'b100, 8'd9, 8'd9, K_NOT);
        checks++;
        if (bus.nextState !== READY) begin errors++; $display("FAIL clear_next got=%0d exp=1", bus.nextState); end
        tick(8'd0, READY);
        drive(3'b010, 8'd1, 8'd1, K_AND);
        tick(8'd1, RUNNING);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL sub_clear out/state got=%h/%0d exp=%h/%0d", g.out, g.state, e.out, e.state); end
        end
    endtask
    task automatic test_logic();
        obs_t e, g;
        drive(3'b010, 8'd50, 8'd25, K_XOR);
        tick(8'd43, RUNNING);
        drive(3'b010, 8'd50, 8'd25, K_OR);
        tick(8'd59, RUNNING);
        drive(3'b010, 8'd50, 8'd25, K_AND);
        tick(8'd16, RUNNING);
        drive(3'b010, 8'd129, 8'd77, K_NOT);
        tick(8'd126, RUNNING);
        drive(3'b010, 8'd9, 8'd3, K_SUB | K_ADD);
        tick(8'd6, RUNNING);
        drive(3'b010, 8'd9, 8'd3, 7'd0);
        tick(8'd0, RUNNING);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL logic out/state got=%h/%0d exp=%h/%0d", g.out, g.state, e.out, e.state); end
        end
    endtask
    task automatic test_persist();
        obs_t e, g;
        drive(3'b010, 8'd4, 8'd8, K_ADD);
        tick(8'd12, RUNNING);
        drive(3'b001, 8'd99, 8'd8, K_ADD);
        checks++;
        if (bus.final1 !== 8'd12) begin errors++; $display("FAIL persist_a got=%h exp=0c", bus.final1); end
        tick(8'd20, RUNNING);
        drive(3'b011, 8'd7, 8'd1, K_ADD);
        checks++;
        if (bus.final1 !== 8'd7) begin errors++; $display("FAIL load_prio_a got=%h exp=07", bus.final1); end
        tick(8'd8, RUNNING);
        drive(3'b000, 8'd6, 8'd1, K_ADD);
        tick(8'd7, RUNNING);
        drive(3'b010, 8'd200, 8'd100, K_ADD);
        checks++;
        if (bus.nextState !== RUN_ERR) begin errors++; $display("FAIL add_ovf_next got=%0d exp=3", bus.nextState); end
        tick(ADD_OVF, RUN_ERR);
        drive(3'b010, 8'd0, 8'd0, K_OR);
        tick(8'd0, READY);
        drive(3'b001, 8'd99, 8'd5, K_ADD);
        checks++;
        if (bus.final1 !== 8'd0) begin errors++; $display("FAIL persist_zero_a got=%h exp=00", bus.final1); end
        tick(8'd5, RUNNING);
        drive(3'b010, 8'd10, 8'd5, K_ADD);
        tick(8'd15, RUNNING);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL persist out/state got=%h/%0d exp=%h/%0d", g.out, g.state, e.out, e.state); end
        end
    endtask
    task automatic test_power_off();
        obs_t e, g;
        bus.on = 1'b0;
        drive(3'b010, 8'd1, 8'd1, K_MUL);
        checks++;
        if (bus.nextState !== OFF) begin errors++; $display("FAIL off_next got=%0d exp=0", bus.nextState); end
        tick(8'd15, OFF);
        tick(8'd15, OFF);
        bus.on = 1'b1;
        drive(3'b010, 8'd3, 8'd3, K_ADD);
        tick(8'd6, READY);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL power out/state got=%h/%0d exp=%h/%0d", g.out, g.state, e.out, e.state); end
        end
    endtask
    task automatic test_async_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.out !== 8'd0) begin errors++; $display("FAIL areset_out got=%h exp=00", bus.out); end
        checks++;
        if (bus.currState !== OFF) begin errors++; $display("FAIL areset_state got=%0d exp=0", bus.currState); end
        @(negedge clk);
        checks++;
        if (bus.out !== 8'd0 || bus.currState !== OFF) begin
            errors++; $display("FAIL areset_hold got=%h/%0d exp=00/0", bus.out, bus.currState);
        end
        rst = 1'b1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        test_reset();
        test_mul();
        test_sub_clear();
        test_logic();
        test_persist();
        test_power_off();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
